// File: rtl/seg_to_count_decoder.sv
// Decodes a four-digit seven-segment display snapshot into its decimal value,
// one digit per clock, most significant digit first, with a ready/valid handshake on each side.
module seg_to_count_decoder #(
    parameter int ACTIVE_LOW    = 1,
    parameter int LEADING_BLANK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] hex_arr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [13:0] count,
    output logic        err,
    output logic [1:0]  err_digit,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

    state_t      state_reg, state_next;
    logic [27:0] hex_reg, hex_next;
    logic [13:0] acc_reg, acc_next;
    logic [1:0]  idx_reg, idx_next;
    logic        err_reg, err_next;
    logic [1:0]  err_digit_reg, err_digit_next;
    logic        lead_blank_reg, lead_blank_next;

    // Packed result: {is_blank, is_numeral, value[3:0]}. Takes active-low codes.
    function automatic logic [5:0] decode_seg(input logic [6:0] c);
        case (c)
            7'h40:   decode_seg = 6'b01_0000;
            7'h79:   decode_seg = 6'b01_0001;
            7'h24:   decode_seg = 6'b01_0010;
            7'h30:   decode_seg = 6'b01_0011;
            7'h19:   decode_seg = 6'b01_0100;
            7'h12:   decode_seg = 6'b01_0101;
            7'h02:   decode_seg = 6'b01_0110;
            7'h78:   decode_seg = 6'b01_0111;
            7'h00:   decode_seg = 6'b01_1000;
            7'h10:   decode_seg = 6'b01_1001;
            7'h7F:   decode_seg = 6'b10_0000;
            default: decode_seg = 6'b00_0000;
        endcase
    endfunction

    logic [5:0] dig_info [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [6:0] norm_code;
            assign norm_code    = (ACTIVE_LOW != 0) ? hex_reg[gi*7 +: 7] : ~hex_reg[gi*7 +: 7];
            assign dig_info[gi] = decode_seg(norm_code);
        end
    endgenerate

    logic [5:0] cur_info;
    logic       cur_blank;
    logic       cur_numeral;
    logic       step_valid;
    logic [3:0] step_val;

    assign cur_info    = dig_info[idx_reg];
    assign cur_blank   = cur_info[5];
    assign cur_numeral = cur_info[4];
    // A blank is only a zero while everything to its left has also been blank.
    assign step_valid  = cur_numeral || (cur_blank && (LEADING_BLANK != 0) && lead_blank_reg);
    assign step_val    = step_valid ? cur_info[3:0] : 4'd0;

    always_comb begin
        state_next      = state_reg;
        hex_next        = hex_reg;
        acc_next        = acc_reg;
        idx_next        = idx_reg;
        err_next        = err_reg;
        err_digit_next  = err_digit_reg;
        lead_blank_next = lead_blank_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    hex_next        = hex_arr;
                    acc_next        = 14'd0;
                    idx_next        = 2'd3;
                    err_next        = 1'b0;
                    err_digit_next  = 2'd0;
                    lead_blank_next = 1'b1;
                    state_next      = DECODE;
                end
            end
            DECODE: begin
                acc_next        = (acc_reg << 3) + (acc_reg << 1) + {10'd0, step_val};
                lead_blank_next = lead_blank_reg && cur_blank;
                if (!step_valid && !err_reg) begin
                    err_next       = 1'b1;
                    err_digit_next = idx_reg;
                end
                idx_next = idx_reg - 2'd1;
                if (idx_reg == 2'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            hex_reg        <= 28'd0;
            acc_reg        <= 14'd0;
            idx_reg        <= 2'd0;
            err_reg        <= 1'b0;
            err_digit_reg  <= 2'd0;
            lead_blank_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hex_reg        <= hex_next;
            acc_reg        <= acc_next;
            idx_reg        <= idx_next;
            err_reg        <= err_next;
            err_digit_reg  <= err_digit_next;
            lead_blank_reg <= lead_blank_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign count     = err_reg ? 14'd0 : acc_reg;
    assign err       = err_reg;
    assign err_digit = err_digit_reg;

endmodule

// File: tb/tb_seg_to_count_decoder.sv
// Directed bench for seg_to_count_decoder: three parameter variants driven in lockstep,
// each snapshot checked for latency, decoded value, error reporting and handshake behaviour.
module tb_seg_to_count_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] hex_arr;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_d [3];
    logic [13:0] count_d    [3];
    logic        err_d      [3];
    logic [1:0]  err_digit_d[3];
    logic        out_valid_d[3];

    int tests_run = 0;
    int tests_failed = 0;
    int sel = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: blanks never valid; 2: active-high segments.
    seg_to_count_decoder #(.ACTIVE_LOW(1), .LEADING_BLANK(1)) u_dut (
        .clk(clk), .rst(rst), .hex_arr(hex_arr), .in_valid(in_valid), .in_ready(in_ready_d[0]),
        .count(count_d[0]), .err(err_d[0]), .err_digit(err_digit_d[0]),
        .out_valid(out_valid_d[0]), .out_ready(out_ready));

    seg_to_count_decoder #(.ACTIVE_LOW(1), .LEADING_BLANK(0)) u_dut_lb0 (
        .clk(clk), .rst(rst), .hex_arr(hex_arr), .in_valid(in_valid), .in_ready(in_ready_d[1]),
        .count(count_d[1]), .err(err_d[1]), .err_digit(err_digit_d[1]),
        .out_valid(out_valid_d[1]), .out_ready(out_ready));

    seg_to_count_decoder #(.ACTIVE_LOW(0), .LEADING_BLANK(1)) u_dut_al0 (
        .clk(clk), .rst(rst), .hex_arr(hex_arr), .in_valid(in_valid), .in_ready(in_ready_d[2]),
        .count(count_d[2]), .err(err_d[2]), .err_digit(err_digit_d[2]),
        .out_valid(out_valid_d[2]), .out_ready(out_ready));

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_out_valid(input string tag);
        int lat = 0;
        while (!out_valid_d[sel] && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, 4);
    endtask

    task automatic run_snapshot(input int s, input string tag, input logic [27:0] h,
                                input int exp_count, input int exp_err, input int exp_digit);
        sel = s;
        @(negedge clk);
        hex_arr  = h;
        in_valid = 1'b1;
        check({tag, ".in_ready"}, int'(in_ready_d[sel]), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        hex_arr  = 28'h5A5A5A5;
        wait_out_valid(tag);
        check({tag, ".count"}, int'(count_d[sel]), exp_count);
        check({tag, ".err"}, int'(err_d[sel]), exp_err);
        check({tag, ".err_digit"}, int'(err_digit_d[sel]), exp_digit);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".release"}, int'(out_valid_d[sel]), 0);
        $display("[TB] %s: hex=%07h count=%0d err=%0d err_digit=%0d", tag, h,
                 count_d[sel], err_d[sel], err_digit_d[sel]);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        hex_arr   = 28'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.in_ready", int'(in_ready_d[0]), 1);
        check("reset.out_valid", int'(out_valid_d[0]), 0);
        check("reset.count", int'(count_d[0]), 0);
        check("reset.err", int'(err_d[0]), 0);
        check("reset.err_digit", int'(err_digit_d[0]), 0);
        rst = 1'b0;

        run_snapshot(0, "d1234", {7'h79, 7'h24, 7'h30, 7'h19}, 1234, 0, 0);
        run_snapshot(0, "d5678", {7'h12, 7'h02, 7'h78, 7'h00}, 5678, 0, 0);
        run_snapshot(0, "d9999", {7'h10, 7'h10, 7'h10, 7'h10}, 9999, 0, 0);
        run_snapshot(0, "lead_blank", {7'h7F, 7'h7F, 7'h79, 7'h40}, 10, 0, 0);
        run_snapshot(1, "lb0_blank", {7'h7F, 7'h7F, 7'h79, 7'h40}, 0, 1, 3);
        run_snapshot(0, "embedded_blank", {7'h79, 7'h7F, 7'h40, 7'h40}, 0, 1, 2);
        run_snapshot(0, "bad_digit0", {7'h79, 7'h24, 7'h30, 7'h7E}, 0, 1, 0);
        run_snapshot(0, "first_bad", {7'h7E, 7'h7E, 7'h40, 7'h40}, 0, 1, 3);
        run_snapshot(0, "all_blank", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 0, 0, 0);
        run_snapshot(2, "al0_1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, 1234, 0, 0);

        // Consumer stalls: result must hold and new snapshots must be refused.
        sel = 0;
        out_ready = 1'b0;
        @(negedge clk);
        hex_arr  = {7'h79, 7'h24, 7'h30, 7'h19};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid("stall");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            hex_arr  = {7'h10, 7'h10, 7'h10, 7'h10};
            @(posedge clk);
            @(negedge clk);
            check("stall.out_valid", int'(out_valid_d[0]), 1);
            check("stall.count", int'(count_d[0]), 1234);
            check("stall.in_ready", int'(in_ready_d[0]), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall.release", int'(out_valid_d[0]), 0);
        check("stall.idle", int'(in_ready_d[0]), 1);
        $display("[TB] stall: held 1234 for 3 cycles then released");

        // Reset in the middle of decoding aborts the snapshot.
        @(negedge clk);
        hex_arr  = {7'h79, 7'h24, 7'h30, 7'h19};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort.in_ready", int'(in_ready_d[0]), 1);
        check("abort.out_valid", int'(out_valid_d[0]), 0);
        check("abort.count", int'(count_d[0]), 0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid_d[0]) seen = 1'b1;
        end
        check("abort.no_stale", int'(seen), 0);
        $display("[TB] abort: reset during decode, no result emitted");

        run_snapshot(0, "post_reset", {7'h78, 7'h40, 7'h79, 7'h02}, 7016, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
